wide_add_seq: RTL and testbench

//  Upstream sequencer for the 32-bit two-stage pipelined carry-lookahead adder.

---
 rtl/wide_add_pkg.sv | 19 +
 rtl/wide_add_seq_if.sv | 28 ++
 rtl/wide_add_seq.sv | 106 ++++++++++
 tb/tb_wide_add_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
// rtl/wide_add_pkg.sv - shared types and constants for the wide-add sequencer
// Limb width, FSM state encoding and index-width helper.
package wide_add_pkg;

  localparam int ADD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  // Width needed to index n items; never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wide_add_seq_if.sv
// rtl/wide_add_seq_if.sv - operand/result handshake bundle for wide_add_seq
// Upstream operand pair in, downstream wide result out.
interface wide_add_seq_if #(
  parameter int LIMBS = 4
);

  logic                               in_valid;
  logic                               in_ready;
  logic [wide_add_pkg::ADD_W*LIMBS-1:0] in_a;
  logic [wide_add_pkg::ADD_W*LIMBS-1:0] in_b;
  logic                               in_cin;
  logic                               in_sub;
  logic                               out_valid;
  logic                               out_ready;
  logic [wide_add_pkg::ADD_W*LIMBS-1:0] out_sum;
  logic                               out_cout;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );

endinterface

// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - limb-serial sequencer around a pipelined 32-bit adder
// Feeds one limb per 1+ADD_LAT cycles, chains carry, assembles the wide sum.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int LIMBS   = 4,
  parameter int ADD_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  wide_add_seq_if.slave    s,
  output logic [ADD_W-1:0] add_a,
  output logic [ADD_W-1:0] add_b,
  output logic             add_cin,
  input  logic [ADD_W-1:0] add_sum,
  input  logic             add_cout,
  output logic             busy
);

  localparam int W  = ADD_W * LIMBS;
  localparam int IW = idx_w(LIMBS);
  localparam int CW = idx_w(ADD_LAT);

  state_t         state;
  state_t         state_nx;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  wait_cnt;
  logic           carry;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   sum_q;
  logic           last_limb;
  logic           sum_ready;
  logic           drive;

  assign last_limb = (idx == IW'(LIMBS - 1));
  // The adder has no valid: its output is trusted only when the count expires.
  assign sum_ready = (state == WAIT) && (wait_cnt == '0);
  assign drive     = (state == ISSUE) || (state == WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (s.in_valid) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (sum_ready) state_nx = last_limb ? DONE : ISSUE;
      DONE:    if (s.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      wait_cnt <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s.in_valid) begin
            a_q   <= s.in_a;
            // Subtract folds into add: A + ~B + 1.
            b_q   <= s.in_sub ? ~s.in_b : s.in_b;
            carry <= s.in_sub ? 1'b1 : s.in_cin;
            idx   <= '0;
          end
        end
        ISSUE: begin
          wait_cnt <= CW'(ADD_LAT - 1);
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            sum_q[int'(idx)*ADD_W +: ADD_W] <= add_sum;
            carry                           <= add_cout;
            if (!last_limb) idx <= idx + 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign add_a   = drive ? a_q[int'(idx)*ADD_W +: ADD_W] : '0;
  assign add_b   = drive ? b_q[int'(idx)*ADD_W +: ADD_W] : '0;
  assign add_cin = drive & carry;

  assign s.in_ready  = (state == IDLE);
  assign s.out_valid = (state == DONE);
  assign s.out_sum   = sum_q;
  assign s.out_cout  = (state == DONE) & carry;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_wide_add_seq.sv
// tb/tb_wide_add_seq.sv - directed self-checking bench for wide_add_seq
// Uses a two-stage registered 32-bit adder model in the loop.
module tb_wide_add_seq;
  import wide_add_pkg::*;

  localparam int LIMBS   = 4;
  localparam int ADD_LAT = 2;
  localparam int W       = ADD_W * LIMBS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        add_cin;
  logic        add_cout;
  logic        busy;
  logic [32:0] st1;
  logic [32:0] st2;
  int          n_assert = 0;
  int          n_fail   = 0;

  wide_add_seq_if #(.LIMBS(LIMBS)) bus ();

  wide_add_seq #(.LIMBS(LIMBS), .ADD_LAT(ADD_LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .s       (bus.slave),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_cin (add_cin),
    .add_sum (add_sum),
    .add_cout(add_cout),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      st1 <= '0;
      st2 <= '0;
    end else begin
      st1 <= {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};
      st2 <= st1;
    end
  end
  assign add_sum  = st2[31:0];
  assign add_cout = st2[32];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair and wait (bounded) for out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, output int lat, output logic cin_l1,
                        output logic rdy_busy);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_sub   = sub;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat      = 0;
    cin_l1   = 1'b0;
    rdy_busy = 1'b1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      if (lat == 1) rdy_busy = bus.in_ready;
      if (lat == 3) cin_l1 = add_cin;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    int          vcnt;
    logic        cin_l1;
    logic        rdy_busy;
    logic [W-1:0] ones;
    logic [W-1:0] held_sum;
    logic        held_cout;

    ones          = '1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", W'(bus.in_ready), W'(1));
    check("rst_out_valid", W'(bus.out_valid), W'(0));
    check("rst_out_sum", bus.out_sum, '0);
    check("rst_out_cout", W'(bus.out_cout), W'(0));
    check("rst_add_a", W'(add_a), W'(0));
    check("rst_busy", W'(busy), W'(0));
    rst = 1'b0;
    tick();

    run_op(W'(1), W'(1), 1'b0, 1'b0, lat, cin_l1, rdy_busy);
    check("basic_latency", W'(lat), W'(12));
    check("basic_sum", bus.out_sum, W'(2));
    check("basic_cout", W'(bus.out_cout), W'(0));
    check("basic_in_ready_busy", W'(rdy_busy), W'(0));
    consume();
    check("basic_in_ready_after", W'(bus.in_ready), W'(1));
    check("basic_out_valid_after", W'(bus.out_valid), W'(0));

    run_op(ones, W'(1), 1'b0, 1'b0, lat, cin_l1, rdy_busy);
    check("ripple_latency", W'(lat), W'(12));
    check("ripple_sum", bus.out_sum, '0);
    check("ripple_cout", W'(bus.out_cout), W'(1));
    consume();

    run_op(W'(32'hFFFF_FFFF), W'(1), 1'b0, 1'b0, lat, cin_l1, rdy_busy);
    check("limb_sum", bus.out_sum, W'(64'h1_0000_0000));
    check("limb_cout", W'(bus.out_cout), W'(0));
    check("limb1_add_cin", W'(cin_l1), W'(1));
    consume();

    run_op(W'(5), W'(7), 1'b0, 1'b1, lat, cin_l1, rdy_busy);
    check("sub_neg_sum", bus.out_sum, ones - W'(1));
    check("sub_neg_cout", W'(bus.out_cout), W'(0));
    consume();

    run_op(W'(7), W'(5), 1'b1, 1'b1, lat, cin_l1, rdy_busy);
    check("sub_pos_sum", bus.out_sum, W'(2));
    check("sub_pos_cout", W'(bus.out_cout), W'(1));
    consume();

    run_op(W'(10), W'(20), 1'b1, 1'b0, lat, cin_l1, rdy_busy);
    held_sum  = bus.out_sum;
    held_cout = bus.out_cout;
    check("bp_sum", held_sum, W'(31));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_sum", bus.out_sum, W'(31));
      check("bp_hold_cout", W'(bus.out_cout), W'(held_cout));
      check("bp_hold_valid", W'(bus.out_valid), W'(1));
      check("bp_hold_in_ready", W'(bus.in_ready), W'(0));
    end
    consume();
    check("bp_release_in_ready", W'(bus.in_ready), W'(1));
    check("bp_release_valid", W'(bus.out_valid), W'(0));

    // Abort in the first WAIT cycle of limb 2, after limbs 0 and 1 were written.
    bus.in_a     = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    bus.in_b     = {4{32'h0000_0001}};
    bus.in_cin   = 1'b0;
    bus.in_sub   = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (7) tick();
    check("abort_partial_sum", bus.out_sum, {64'h0, 32'h3333_3334, 32'h4444_4445});
    check("abort_busy_before", W'(busy), W'(1));
    rst = 1'b1;
    #1;
    check("abort_out_sum", bus.out_sum, '0);
    check("abort_out_valid", W'(bus.out_valid), W'(0));
    check("abort_add_a", W'(add_a), W'(0));
    check("abort_busy", W'(busy), W'(0));
    check("abort_in_ready", W'(bus.in_ready), W'(1));
    tick();
    rst  = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid === 1'b1) vcnt++;
    end
    check("abort_no_valid", W'(vcnt), W'(0));

    run_op(W'(3), W'(4), 1'b0, 1'b0, lat, cin_l1, rdy_busy);
    check("post_abort_latency", W'(lat), W'(12));
    check("post_abort_sum", bus.out_sum, W'(7));
    check("post_abort_cout", W'(bus.out_cout), W'(0));
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
